// File: rtl/multicycle_control.sv
// ============================================================================
// multicycle_control : FSM sequencer for a multicycle RISC-V style datapath
// Revision: 1.0
// ============================================================================
`default_nettype none

module multicycle_control #(
  parameter int OP_W    = 7,
  parameter int ALUOP_W = 2,
  parameter int CNT_W   = 32,
  parameter logic [OP_W-1:0]    OP_RTYPE    = OP_W'(7'b0110011),
  parameter logic [OP_W-1:0]    OP_ITYPE    = OP_W'(7'b0010011),
  parameter logic [OP_W-1:0]    OP_LOAD     = OP_W'(7'b0000011),
  parameter logic [OP_W-1:0]    OP_STORE    = OP_W'(7'b0100011),
  parameter logic [OP_W-1:0]    OP_BRANCH   = OP_W'(7'b1100011),
  parameter logic [ALUOP_W-1:0] ALUOP_ADD   = ALUOP_W'(0),
  parameter logic [ALUOP_W-1:0] ALUOP_SUB   = ALUOP_W'(1),
  parameter logic [ALUOP_W-1:0] ALUOP_RTYPE = ALUOP_W'(2),
  parameter logic [ALUOP_W-1:0] ALUOP_ITYPE = ALUOP_W'(3)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               halt_i,
  input  logic [OP_W-1:0]    op_i,
  input  logic               imem_ready_i,
  input  logic               dmem_ready_i,
  output logic               imem_req_o,
  output logic               ir_write_o,
  output logic               pc_write_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic               reg_write_o,
  output logic               mem_to_reg_o,
  output logic               alu_src_o,
  output logic               branch_o,
  output logic [ALUOP_W-1:0] alu_op_o,
  output logic               illegal_o,
  output logic               busy_o,
  output logic [CNT_W-1:0]   instret_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [CNT_W-1:0]  instret_q;
  logic              retire;
  logic              op_legal;

  assign op_legal = (op_i == OP_RTYPE) || (op_i == OP_ITYPE) || (op_i == OP_LOAD) ||
                    (op_i == OP_STORE) || (op_i == OP_BRANCH);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      if (retire) instret_q <= instret_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    retire       = 1'b0;
    imem_req_o   = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    reg_write_o  = 1'b0;
    mem_to_reg_o = 1'b0;
    alu_src_o    = 1'b0;
    branch_o     = 1'b0;
    alu_op_o     = ALUOP_ADD;
    illegal_o    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req_o = 1'b1;
        if (imem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        op_d = op_i;
        if (op_legal) begin
          state_d = S_EXEC;
        end else begin
          illegal_o = 1'b1;
          state_d   = halt_i ? S_IDLE : S_FETCH;
        end
      end
      S_EXEC: begin
        // From here on only the latched opcode steers the datapath.
        if (op_q == OP_RTYPE) begin
          alu_op_o = ALUOP_RTYPE;
          state_d  = S_WB;
        end else if (op_q == OP_ITYPE) begin
          alu_op_o  = ALUOP_ITYPE;
          alu_src_o = 1'b1;
          state_d   = S_WB;
        end else if (op_q == OP_BRANCH) begin
          alu_op_o = ALUOP_SUB;
          branch_o = 1'b1;
          retire   = 1'b1;
          state_d  = halt_i ? S_IDLE : S_FETCH;
        end else begin
          alu_op_o  = ALUOP_ADD;
          alu_src_o = 1'b1;
          state_d   = S_MEM;
        end
      end
      S_MEM: begin
        if (op_q == OP_LOAD) begin
          mem_read_o = 1'b1;
          if (dmem_ready_i) state_d = S_WB;
        end else begin
          mem_write_o = 1'b1;
          if (dmem_ready_i) begin
            retire  = 1'b1;
            state_d = halt_i ? S_IDLE : S_FETCH;
          end
        end
      end
      S_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = (op_q == OP_LOAD);
        retire       = 1'b1;
        state_d      = halt_i ? S_IDLE : S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o    = (state_q != S_IDLE);
  assign instret_o = instret_q;

endmodule

`default_nettype wire
